// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Readback monitor for a scanned 7-segment bus. Decodes each
//            digit slot and commits debounced {dp,value} per digit position.
// Options  : SEG_SCAN_DEC_HEX_EN - also accept the A,b,C,d,E,F glyphs.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int SETTLE     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   digit_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     upd,
    output logic                  err
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int MW = $clog2(STABLE_CNT + 1);

    localparam logic [SW-1:0] c_settle    = SW'(SETTLE);
    localparam logic [SW-1:0] c_settle_m1 = SW'(SETTLE - 1);
    localparam logic [MW-1:0] c_stable    = MW'(STABLE_CNT);
    localparam logic [MW-1:0] c_stable_m1 = MW'(STABLE_CNT - 1);
    localparam logic [MW-1:0] c_one       = MW'(1);

    // Returns {ok, value}; ok is 0 for any pattern that is not a known glyph.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        res = 5'h00;
        case (pat)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
`ifdef SEG_SCAN_DEC_HEX_EN
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
`endif
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [7:0]        r_seg_m;
    logic [7:0]        r_seg_s;
    logic [DIGITS-1:0] r_an_m;
    logic [DIGITS-1:0] r_an_s;
    logic [DIGITS-1:0] r_an_q;
    logic [SW-1:0]     r_slot_cnt;
    logic [4:0]        r_cand [DIGITS];
    logic [MW-1:0]     r_mcnt [DIGITS];

    logic [DIGITS-1:0] w_an_low;
    logic              w_one_hot;
    logic              w_new_slot;
    logic              w_sample;
    logic [4:0]        w_dec;
    logic              w_dec_ok;
    logic [4:0]        w_smp;
    logic [DIGITS-1:0] w_hit;
    logic [DIGITS-1:0] w_reload;
    logic [DIGITS-1:0] w_commit;

    // Anode sync resets to the blanked value so the first slot after reset
    // always begins with a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_m <= '0;
            r_seg_s <= '0;
            r_an_m  <= '1;
            r_an_s  <= '1;
            r_an_q  <= '1;
        end else begin
            r_seg_m <= seg_in;
            r_seg_s <= r_seg_m;
            r_an_m  <= an_in;
            r_an_s  <= r_an_m;
            r_an_q  <= r_an_s;
        end
    end

    assign w_new_slot = (r_an_s != r_an_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
        end else if (w_new_slot) begin
            r_slot_cnt <= '0;
        end else if (r_slot_cnt != c_settle) begin
            r_slot_cnt <= r_slot_cnt + SW'(1);
        end
    end

    assign w_an_low  = ~r_an_s;
    assign w_one_hot = (w_an_low != '0) && ((w_an_low & (w_an_low - DIGITS'(1))) == '0);
    assign w_sample  = w_one_hot && !w_new_slot && (r_slot_cnt == c_settle_m1);
    assign w_dec     = seg_decode(r_seg_s[6:0]);
    assign w_dec_ok  = w_dec[4];
    assign w_smp     = {r_seg_s[7], w_dec[3:0]};

    // A matching sample equals cand, so the committed value is always w_smp.
    always_comb begin
        w_hit    = '0;
        w_reload = '0;
        w_commit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_hit[k]    = w_sample && !r_an_s[k] && w_dec_ok;
            w_reload[k] = (w_smp != r_cand[k]) || (r_mcnt[k] == '0);
            w_commit[k] = w_hit[k] && (w_reload[k] ? (c_stable == c_one)
                                                   : (r_mcnt[k] == c_stable_m1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DIGITS; k++) begin
                r_cand[k] <= '0;
                r_mcnt[k] <= '0;
            end
            digit_out <= '0;
            dp_out    <= '0;
            valid     <= '0;
            upd       <= '0;
            err       <= 1'b0;
        end else begin
            upd <= '0;
            err <= w_sample && !w_dec_ok;
            for (int k = 0; k < DIGITS; k++) begin
                if (w_sample && !r_an_s[k] && !w_dec_ok) begin
                    r_mcnt[k] <= '0;
                end else if (w_hit[k]) begin
                    if (w_reload[k]) begin
                        r_cand[k] <= w_smp;
                        r_mcnt[k] <= c_one;
                    end else if (r_mcnt[k] != c_stable) begin
                        r_mcnt[k] <= r_mcnt[k] + c_one;
                    end
                end
                if (w_commit[k]) begin
                    digit_out[4*k +: 4] <= w_smp[3:0];
                    dp_out[k]           <= w_smp[4];
                    valid[k]            <= 1'b1;
                    upd[k]              <= !valid[k] || ({dp_out[k], digit_out[4*k +: 4]} != w_smp);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// Testbench for seg_scan_decoder: directed slot table, a mid-slot reset
// sequence, and randomized scans checked against a slot-level model.
module tb_seg_scan_decoder;

    localparam int DIGITS     = 4;
    localparam int SETTLE     = 4;
    localparam int STABLE_CNT = 3;
`ifdef SEG_SCAN_DEC_HEX_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif
    localparam logic [6:0] GLYPHS [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic                  clk    = 1'b0;
    logic                  rst_n  = 1'b0;
    logic [7:0]            seg_in = 8'h00;
    logic [DIGITS-1:0]     an_in  = '1;
    logic [4*DIGITS-1:0]   digit_out;
    logic [DIGITS-1:0]     dp_out;
    logic [DIGITS-1:0]     valid;
    logic [DIGITS-1:0]     upd;
    logic                  err;

    seg_scan_decoder #(
        .DIGITS     (DIGITS),
        .SETTLE     (SETTLE),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .digit_out (digit_out),
        .dp_out    (dp_out),
        .valid     (valid),
        .upd       (upd),
        .err       (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int upd_seen [DIGITS] = '{default: 0};
    int upd_base [DIGITS] = '{default: 0};
    int err_seen   = 0;
    int err_base   = 0;
    int multi_seen = 0;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err) err_seen <= err_seen + 1;
            if ($countones(upd) > 1) multi_seen <= multi_seen + 1;
            for (int k = 0; k < DIGITS; k++)
                if (upd[k]) upd_seen[k] <= upd_seen[k] + 1;
        end
    end

    // Reference model state, one entry per digit position.
    logic [4:0] m_cand [DIGITS];
    logic [4:0] m_val  [DIGITS];
    int         m_cnt  [DIGITS];
    bit         m_valid[DIGITS];
    int         m_upd  [DIGITS];
    int         m_err;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        int          len;
        bit          chk;
        string       name;
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  vld;
        int          nupd;
        int          nerr;
    } vec_t;
    vec_t tbl [$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int n);
        an_in = '1;
        repeat (n) tick();
    endtask

    // One scan slot of len cycles followed by a short blank so that repeated
    // slots on the same digit are seen as separate slots.
    task automatic apply_slot(input logic [3:0] an, input logic [7:0] seg, input int len);
        an_in  = an;
        seg_in = seg;
        repeat (len) tick();
        an_in = '1;
        repeat (2) tick();
    endtask

    task automatic snap();
        for (int k = 0; k < DIGITS; k++) upd_base[k] = upd_seen[k];
        err_base = err_seen;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [15:0] dig, input logic [3:0] dp,
                               input logic [3:0] vld, input int nupd, input int nerr);
        int ut;
        ut = 0;
        for (int k = 0; k < DIGITS; k++) ut += upd_seen[k] - upd_base[k];
        chk({name, "/digit_out"}, 32'(digit_out), 32'(dig));
        chk({name, "/dp_out"},    32'(dp_out),    32'(dp));
        chk({name, "/valid"},     32'(valid),     32'(vld));
        chk({name, "/upd_count"}, ut,             nupd);
        chk({name, "/err_count"}, err_seen - err_base, nerr);
        snap();
    endtask

    task automatic add(input logic [3:0] an, input logic [7:0] seg, input int len);
        vec_t v;
        v = '{an, seg, len, 1'b0, "", 16'h0, 4'h0, 4'h0, 0, 0};
        tbl.push_back(v);
    endtask

    task automatic addc(input logic [3:0] an, input logic [7:0] seg, input int len, input string name,
                        input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] vld,
                        input int nupd, input int nerr);
        vec_t v;
        v = '{an, seg, len, 1'b1, name, dig, dp, vld, nupd, nerr};
        tbl.push_back(v);
    endtask

    function automatic int ref_decode(input logic [6:0] p);
        int n;
        n = HEX_EN ? 16 : 10;
        for (int i = 0; i < n; i++)
            if (GLYPHS[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DIGITS; k++) begin
            m_cand[k] = '0; m_val[k] = '0; m_cnt[k] = 0; m_valid[k] = 1'b0; m_upd[k] = 0;
        end
        m_err = 0;
    endtask

    // A slot is read once if it has exactly one anode low and lasts past the
    // settle window (counting starts the cycle after the synchronized edge).
    task automatic model_slot(input logic [3:0] an, input logic [7:0] seg, input int len);
        logic [3:0] low;
        logic [4:0] smp;
        int         k;
        int         v;
        int         prev;
        bit         reloaded;
        low = ~an;
        if ($countones(low) != 1 || len <= SETTLE) return;
        k = 0;
        for (int i = 0; i < DIGITS; i++) if (low[i]) k = i;
        v = ref_decode(seg[6:0]);
        if (v < 0) begin
            m_err++;
            m_cnt[k] = 0;
            return;
        end
        smp      = {seg[7], 4'(v)};
        prev     = m_cnt[k];
        reloaded = 1'b0;
        if (m_cnt[k] == 0 || smp != m_cand[k]) begin
            m_cand[k] = smp;
            m_cnt[k]  = 1;
            reloaded  = 1'b1;
        end else if (m_cnt[k] < STABLE_CNT) begin
            m_cnt[k]++;
        end
        if (m_cnt[k] == STABLE_CNT && (reloaded || prev != STABLE_CNT)) begin
            if (!m_valid[k] || m_val[k] != m_cand[k]) m_upd[k]++;
            m_val[k]   = m_cand[k];
            m_valid[k] = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] d_hex;
        int          e_hex1;
        int          e_hex2;
        int          u_hex2;
        logic [3:0]  an;
        logic [3:0]  prev_an;
        logic [7:0]  seg;
        logic [7:0]  sticky [DIGITS];
        logic [15:0] exp_dig;
        logic [3:0]  exp_dp;
        logic [3:0]  exp_vld;
        int          lens [6] = '{2, 3, 6, 7, 8, 10};
        int          len;
        int          k;
        int          r;

        d_hex  = HEX_EN ? 16'h9A70 : 16'h9370;
        e_hex1 = HEX_EN ? 0 : 1;
        e_hex2 = HEX_EN ? 0 : 3;
        u_hex2 = HEX_EN ? 1 : 0;

        add (4'b1110, 8'h5B, 8);
        addc(4'b1110, 8'h5B, 8, "two_samples", 16'h0000, 4'b0000, 4'b0000, 0, 0);
        addc(4'b1110, 8'h5B, 8, "commit_d0",   16'h0002, 4'b0000, 4'b0001, 1, 0);
        for (int f = 0; f < 3; f++) begin
            add(4'b1110, 8'hBF, 8);
            add(4'b1101, 8'h06, 8);
            add(4'b1011, 8'h4F, 8);
            if (f < 2) add(4'b0111, 8'h6F, 8);
            else       addc(4'b0111, 8'h6F, 8, "round_robin", 16'h9310, 4'b0001, 4'b1111, 4, 0);
        end
        add (4'b1101, 8'h06, 8);
        addc(4'b1101, 8'h07, 8, "d1_glitch",    16'h9310, 4'b0001, 4'b1111, 0, 0);
        add (4'b1101, 8'h06, 8);
        add (4'b1101, 8'h06, 8);
        addc(4'b1101, 8'h06, 8, "d1_same",      16'h9310, 4'b0001, 4'b1111, 0, 0);
        add (4'b1101, 8'h07, 8);
        add (4'b1101, 8'h07, 8);
        add (4'b1101, 8'h07, 8);
        addc(4'b1101, 8'h07, 8, "d1_change",    16'h9370, 4'b0001, 4'b1111, 1, 0);
        add (4'b1101, 8'h06, 8);
        add (4'b1101, 8'h07, 8);
        addc(4'b1101, 8'h07, 8, "d1_restart",   16'h9370, 4'b0001, 4'b1111, 0, 0);
        add (4'b1011, 8'h5B, 8);
        add (4'b1011, 8'h5B, 8);
        add (4'b1011, 8'h77, 8);
        addc(4'b1011, 8'h5B, 8, "d2_err_clear", 16'h9370, 4'b0001, 4'b1111, 0, e_hex1);
        add (4'b1011, 8'h77, 8);
        add (4'b1011, 8'h77, 8);
        addc(4'b1011, 8'h77, 8, "d2_hex",       d_hex, 4'b0001, 4'b1111, u_hex2, e_hex2);
        add (4'b1110, 8'h5B, 3);
        add (4'b1110, 8'h5B, 3);
        addc(4'b1110, 8'h5B, 3, "short_slot",   d_hex, 4'b0001, 4'b1111, 0, 0);
        add (4'b1111, 8'h5B, 8);
        add (4'b1111, 8'h5B, 8);
        addc(4'b1111, 8'h5B, 8, "blanked",      d_hex, 4'b0001, 4'b1111, 0, 0);
        add (4'b1100, 8'h5B, 8);
        add (4'b1100, 8'h5B, 8);
        addc(4'b1100, 8'h5B, 8, "multi_low",    d_hex, 4'b0001, 4'b1111, 0, 0);
        addc(4'b1100, 8'h00, 8, "multi_low_bad", d_hex, 4'b0001, 4'b1111, 0, 0);

        repeat (3) tick();
        chk("reset/digit_out", 32'(digit_out), 32'h0);
        chk("reset/dp_out",    32'(dp_out),    32'h0);
        chk("reset/valid",     32'(valid),     32'h0);
        chk("reset/upd",       32'(upd),       32'h0);
        chk("reset/err",       32'(err),       32'h0);
        rst_n = 1'b1;
        repeat (2) tick();
        snap();

        for (int i = 0; i < tbl.size(); i++) begin
            apply_slot(tbl[i].an, tbl[i].seg, tbl[i].len);
            if (tbl[i].chk) begin
                drain(12);
                check_state(tbl[i].name, tbl[i].dig, tbl[i].dp, tbl[i].vld, tbl[i].nupd, tbl[i].nerr);
            end
        end

        // Reset in the middle of the third matching slot on digit 3.
        apply_slot(4'b0111, 8'h66, 8);
        apply_slot(4'b0111, 8'h66, 8);
        an_in  = 4'b0111;
        seg_in = 8'h66;
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst/digit_out", 32'(digit_out), 32'h0);
        chk("midrst/dp_out",    32'(dp_out),    32'h0);
        chk("midrst/valid",     32'(valid),     32'h0);
        chk("midrst/upd",       32'(upd),       32'h0);
        chk("midrst/err",       32'(err),       32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        snap();
        repeat (8) tick();
        an_in = '1;
        repeat (2) tick();
        apply_slot(4'b0111, 8'h66, 8);
        drain(12);
        check_state("post_rst_two", 16'h0000, 4'b0000, 4'b0000, 0, 0);
        apply_slot(4'b0111, 8'h66, 8);
        drain(12);
        check_state("post_rst_three", 16'h4000, 4'b0000, 4'b1000, 1, 0);

        // Randomized scanning from a clean reset.
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        snap();
        model_reset();
        for (int d = 0; d < DIGITS; d++) sticky[d] = {1'b0, GLYPHS[d]};
        prev_an = '1;
        for (int b = 0; b < 25; b++) begin
            for (int s = 0; s < 10; s++) begin
                do begin
                    r = $urandom_range(0, 9);
                    if (r < 7)       an = ~(4'b0001 << $urandom_range(0, DIGITS - 1));
                    else if (r == 7) an = 4'b1111;
                    else             an = 4'($urandom);
                end while (an == prev_an);
                k = 0;
                for (int i = 0; i < DIGITS; i++) if (!an[i]) k = i;
                if ($urandom_range(0, 99) < 65) begin
                    seg = sticky[k];
                end else begin
                    r = $urandom_range(0, 9);
                    if (r < 6)      seg = {1'($urandom_range(0, 1)), GLYPHS[$urandom_range(0, 9)]};
                    else if (r < 8) seg = {1'b0, GLYPHS[10 + $urandom_range(0, 5)]};
                    else            seg = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) sticky[k] = seg;
                end
                len = lens[$urandom_range(0, 5)];
                model_slot(an, seg, len);
                an_in  = an;
                seg_in = seg;
                repeat (len) tick();
                prev_an = an;
            end
            drain(12);
            prev_an = '1;
            for (int d = 0; d < DIGITS; d++) begin
                exp_dig[4*d +: 4] = m_val[d][3:0];
                exp_dp[d]         = m_val[d][4];
                exp_vld[d]        = m_valid[d];
            end
            chk($sformatf("rand%0d/digit_out", b), 32'(digit_out), 32'(exp_dig));
            chk($sformatf("rand%0d/dp_out", b),    32'(dp_out),    32'(exp_dp));
            chk($sformatf("rand%0d/valid", b),     32'(valid),     32'(exp_vld));
            chk($sformatf("rand%0d/err_count", b), err_seen - err_base, m_err);
            for (int d = 0; d < DIGITS; d++)
                chk($sformatf("rand%0d/upd%0d_count", b, d), upd_seen[d] - upd_base[d], m_upd[d]);
        end

        chk("single_upd_per_cycle", multi_seen, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
